i2c_slave: RTL and testbench
============================

Name: i2c_slave

Overview:
- Single-address I2C target (slave), the responder counterpart to the team's I2C master controller.
- Watches the bus SCL/SDA lines, oversampled by the system clock.
- Detects START, repeated START and STOP, and matches a 7-bit address.
- Acknowledges the address, delivers written bytes to local logic and fetches bytes from local logic for read transfers.
- No clock stretching: SCL is an input only. SDA is open-drain, driven low or released to Z.

Parameters:
- ADDRESS, 7'h50, 7-bit target address compared against the first byte after START.

Ports:
- clk  input  1  system clock; each SCL high or low phase must last at least 6 clk periods
- reset  input  1  asynchronous, active-low reset
- sda  inout  1  I2C data line; output is 0 or Z only
- scl  input  1  I2C clock line
- busy  output  1  high from START until STOP
- addressed  output  1  high while this target is selected (address matched and ACKed) until STOP, START or NACK
- rw  output  1  R/W bit of the current matched transfer (1 = read)
- datareceive  output  8  last byte written by the master
- received  output  1  one-clk pulse: datareceive holds a new byte
- ack_en  input  1  sampled at the received pulse; 1 = ACK the byte, 0 = NACK it
- datasend  input  8  byte to return to the master on a read
- sended  output  1  one-clk pulse: datasend was latched into the shift register and local logic may present the next byte

Behaviour:
- Reset (async, reset=0):
  - sda released (Z); busy, addressed, rw, received and sended are 0; datareceive is 8'h00; state is IDLE.
  - Asserting reset mid-transfer releases sda within the same cycle.
- Input conditioning:
  - scl and sda each pass through a 2-flop synchronizer plus one history flop.
  - Edges are detected on the synchronized values, so detection lags the pins by 3 clk.
- Bus conditions:
  - START = sda falling while scl high. STOP = sda rising while scl high.
  - START in any state: bit counter reset to 7, sda released, addressed=0, go to ADDR. This is a repeated START if busy=1.
  - STOP in any state: sda released, busy=0, addressed=0, go to IDLE.
  - START and STOP take priority over any SCL edge detected in the same cycle.
- Bit timing:
  - Incoming bits are sampled on the SCL rising edge, MSB first.
  - Outgoing bits and ACK are changed on the SCL falling edge.
- States:
  - IDLE: sda released, waiting for START.
  - ADDR: shift 8 bits.
    - After the 8th rising edge, compare bits [7:1] to ADDRESS.
    - Match: latch rw = bit0 and go to ADDR_ACK.
    - Mismatch: go to IGNORE. Address 7'h00 (general call) is never matched unless ADDRESS = 0.
  - ADDR_ACK: drive sda=0 from the next SCL falling edge, set addressed=1.
    - Release at the following falling edge, then go to WR_DATA (rw=0) or RD_DATA (rw=1).
    - For a read, datasend is latched and sended pulses at that same falling edge, and bit7 is driven immediately.
  - WR_DATA: shift 8 bits.
    - On the 8th rising edge, datareceive is updated and received pulses one clk later.
    - ack_en is sampled with the pulse, then go to WR_ACK.
  - WR_ACK:
    - If ack_en=1: drive sda=0 for one SCL low/high period, release at the next falling edge, return to WR_DATA.
    - If ack_en=0: leave sda released, addressed=0, go to IGNORE.
  - RD_DATA: drive the shift register MSB each falling edge (0 means drive low, 1 means release).
    - After the 8th bit, release sda at the next falling edge and go to RD_ACK.
  - RD_ACK: sample sda on the SCL rising edge.
    - 0 (ACK): at the next falling edge, latch datasend, pulse sended, drive bit7, return to RD_DATA.
    - 1 (NACK): addressed=0, go to IGNORE.
  - IGNORE: sda released until START or STOP.
- Boundaries:
  - The bit counter wraps 0→7 per byte.
  - START or STOP in mid-byte discards the partial byte; no received pulse is generated.
  - received and sended never assert in the same cycle.
  - busy rises on START even when the address does not match.

Test Plan:
- Write 0xA0 (addr 0x50 W), then 0x3C, 0x81, ack_en=1, STOP -> ACK on address and both bytes; received pulses twice with datareceive=0x3C then 0x81; busy and addressed return to 0 after STOP.
- Address 0x51 W with ADDRESS=0x50 -> sda never driven low, addressed stays 0, no received pulses, busy=1 until STOP.
- Read 0xA1, datasend=0x5A then 0xC3, master ACKs byte 1 and NACKs byte 2 -> bus shows 0x5A then 0xC3; sended pulses exactly twice; IGNORE after the NACK.
- Write 0xA0 then 0x10, repeated START, 0xA1, read one byte with datasend=0xE7 -> datareceive=0x10; rw becomes 1; bus returns 0xE7.
- ack_en=0 at the second written byte 0x22 -> ACK on byte 1, NACK on 0x22; addressed=0; a third byte produces no received pulse.
- Assert reset low while driving the ACK -> sda goes to Z in the same cycle; all outputs return to reset values; the next START and address 0xA0 is ACKed normally.

Source files
------------

// File: rtl/i2c_slave.sv
`timescale 1ns/1ps
// i2c_slave: single-address I2C target, SCL/SDA oversampled by clk, no clock stretching.
// Ports:
//   clk         system clock (each SCL phase must last >= 6 clk)
//   reset       asynchronous active-low reset
//   sda         open-drain data line (driven 0 or released to Z)
//   scl         bus clock (input only)
//   busy        high from START until STOP
//   addressed   high while this target is selected
//   rw          R/W bit of the current matched transfer (1 = read)
//   datareceive last byte written by the master
//   received    one-clk pulse, datareceive holds a new byte
//   ack_en      sampled with received: 1 = ACK the byte, 0 = NACK it
//   datasend    byte returned to the master on a read
//   sended      one-clk pulse, datasend was latched and the next byte may be presented
module i2c_slave #(
  parameter logic [6:0] ADDRESS = 7'h50
) (
  input  logic       clk,
  input  logic       reset,
  inout  wire        sda,
  input  logic       scl,
  output logic       busy,
  output logic       addressed,
  output logic       rw,
  output logic [7:0] datareceive,
  output logic       received,
  input  logic       ack_en,
  input  logic [7:0] datasend,
  output logic       sended
);
  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE} state_t;
  state_t state, state_n;
  logic [2:0] scl_s, sda_s, cnt, cnt_n;
  logic [7:0] sh, sh_n, dr_n;
  logic drv, drv_n, busy_n, addressed_n, rw_n, rx_pend, rx_pend_n, sended_n;
  logic scl_r, scl_f, sda_in, start, stop;
  assign sda = drv ? 1'b0 : 1'bz;
  // [1] is the synchronized value, [2] its history for edge detection
  assign scl_r = scl_s[1] & ~scl_s[2];
  assign scl_f = ~scl_s[1] & scl_s[2];
  assign sda_in = sda_s[1];
  assign start = scl_s[1] & ~sda_s[1] & sda_s[2];
  assign stop = scl_s[1] & sda_s[1] & ~sda_s[2];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      scl_s <= 3'b111;
      sda_s <= 3'b111;
      state <= IDLE;
      cnt <= 3'd7;
      sh <= 8'h00;
      drv <= 1'b0;
      busy <= 1'b0;
      addressed <= 1'b0;
      rw <= 1'b0;
      datareceive <= 8'h00;
      rx_pend <= 1'b0;
      received <= 1'b0;
      sended <= 1'b0;
    end else begin
      scl_s <= {scl_s[1:0], scl};
      sda_s <= {sda_s[1:0], sda};
      state <= state_n;
      cnt <= cnt_n;
      sh <= sh_n;
      drv <= drv_n;
      busy <= busy_n;
      addressed <= addressed_n;
      rw <= rw_n;
      datareceive <= dr_n;
      rx_pend <= rx_pend_n;
      received <= rx_pend;
      sended <= sended_n;
    end
  // On reads sh holds the bits still to be sent, MSB next, so drv tracks ~sh[7] of the previous shift.
  // The ACK phases use drv itself to tell the driving half from the releasing half.
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    sh_n = sh;
    drv_n = drv;
    busy_n = busy;
    addressed_n = addressed;
    rw_n = rw;
    dr_n = datareceive;
    rx_pend_n = 1'b0;
    sended_n = 1'b0;
    if (start) begin
      busy_n = 1'b1;
      addressed_n = 1'b0;
      drv_n = 1'b0;
      cnt_n = 3'd7;
      state_n = ADDR;
    end else if (stop) begin
      busy_n = 1'b0;
      addressed_n = 1'b0;
      drv_n = 1'b0;
      state_n = IDLE;
    end else
      case (state)
        ADDR:
          if (scl_r) begin
            sh_n = {sh[6:0], sda_in};
            cnt_n = cnt - 3'd1;
            if (cnt == 3'd0) begin
              rw_n = (sh[6:0] == ADDRESS) ? sda_in : rw;
              state_n = (sh[6:0] == ADDRESS) ? ADDR_ACK : IGNORE;
            end
          end
        ADDR_ACK:
          if (scl_f) begin
            if (!drv) begin
              drv_n = 1'b1;
              addressed_n = 1'b1;
            end else if (rw) begin
              sh_n = {datasend[6:0], 1'b1};
              drv_n = ~datasend[7];
              sended_n = 1'b1;
              cnt_n = 3'd7;
              state_n = RD_DATA;
            end else begin
              drv_n = 1'b0;
              cnt_n = 3'd7;
              state_n = WR_DATA;
            end
          end
        WR_DATA:
          if (scl_r) begin
            sh_n = {sh[6:0], sda_in};
            cnt_n = cnt - 3'd1;
            if (cnt == 3'd0) begin
              dr_n = {sh[6:0], sda_in};
              rx_pend_n = 1'b1;
              state_n = WR_ACK;
            end
          end
        WR_ACK:
          if (received && !ack_en) begin
            addressed_n = 1'b0;
            state_n = IGNORE;
          end else if (scl_f) begin
            drv_n = ~drv;
            state_n = drv ? WR_DATA : WR_ACK;
          end
        RD_DATA:
          if (scl_f) begin
            if (cnt == 3'd0) begin
              drv_n = 1'b0;
              state_n = RD_ACK;
            end else begin
              cnt_n = cnt - 3'd1;
              drv_n = ~sh[7];
              sh_n = {sh[6:0], 1'b1};
            end
          end
        RD_ACK:
          // NACK leaves on the rising edge, so any falling edge seen here follows an ACK
          if (scl_r && sda_in) begin
            addressed_n = 1'b0;
            state_n = IGNORE;
          end else if (scl_f) begin
            sh_n = {datasend[6:0], 1'b1};
            drv_n = ~datasend[7];
            sended_n = 1'b1;
            cnt_n = 3'd7;
            state_n = RD_DATA;
          end
        default: drv_n = 1'b0;
      endcase
  end
endmodule

// File: tb/tb_i2c_slave.sv
`timescale 1ns/1ps
// tb_i2c_slave: bus-level master model with scoreboard queues for written and read bytes.
module tb_i2c_slave;
  logic clk = 1'b0, reset = 1'b0, scl = 1'b1, m_low = 1'b0, ack_en = 1'b1;
  logic [7:0] datasend = 8'h00;
  wire sda;
  logic busy, addressed, rw, received, sended;
  logic [7:0] datareceive;
  int n_chk = 0, n_fail = 0, rx_cnt = 0, sd_cnt = 0;
  logic dut_low = 1'b0;
  logic [7:0] exp_rx[$], exp_tx[$], ds_q[$];

  pullup (sda);
  assign sda = m_low ? 1'b0 : 1'bz;
  always #5 clk = ~clk;

  i2c_slave #(.ADDRESS(7'h50)) dut (
    .clk(clk), .reset(reset), .sda(sda), .scl(scl), .busy(busy), .addressed(addressed),
    .rw(rw), .datareceive(datareceive), .received(received), .ack_en(ack_en),
    .datasend(datasend), .sended(sended)
  );

  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (!m_low && sda === 1'b0) dut_low = 1'b1;
        if (received || sended) begin
          n_chk++;
          if (received && sended) begin n_fail++; $display("FAIL rx_tx_overlap: received=%b sended=%b want not both", received, sended); end
        end
        if (received) begin
          rx_cnt++;
          n_chk++;
          if (exp_rx.size() == 0) begin n_fail++; $display("FAIL unexpected_received: datareceive=%h with no byte expected", datareceive); end
          else begin
            e = exp_rx.pop_front();
            if (datareceive !== e) begin n_fail++; $display("FAIL datareceive: got %h want %h", datareceive, e); end
          end
        end
        if (sended) begin
          sd_cnt++;
          if (ds_q.size() != 0) datasend = ds_q.pop_front();
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task sbit(input logic b, output logic r);
    m_low = ~b;
    #60 scl = 1'b1;
    #40 r = sda;
    #40 scl = 1'b0;
    #20;
  endtask

  task start_c;
    m_low = 1'b0;
    #60 scl = 1'b1;
    #40 m_low = 1'b1;
    #40 scl = 1'b0;
    #20;
  endtask

  task stop_c;
    m_low = 1'b1;
    #60 scl = 1'b1;
    #40 m_low = 1'b0;
    #60;
  endtask

  task wr_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) sbit(b[i], r);
    sbit(1'b1, ack);
  endtask

  task rd_byte(output logic [7:0] d, input logic nack);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      sbit(1'b1, r);
      d[i] = r;
    end
    sbit(nack, r);
  endtask

  task test_reset;
    #20;
    n_chk++; if (sda !== 1'b1) begin n_fail++; $display("FAIL reset_sda: got %b want 1 (released)", sda); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_chk++; if (addressed !== 1'b0) begin n_fail++; $display("FAIL reset_addressed: got %b want 0", addressed); end
    n_chk++; if (rw !== 1'b0) begin n_fail++; $display("FAIL reset_rw: got %b want 0", rw); end
    n_chk++; if (received !== 1'b0 || sended !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: got %b%b want 00", received, sended); end
    n_chk++; if (datareceive !== 8'h00) begin n_fail++; $display("FAIL reset_datareceive: got %h want 00", datareceive); end
    reset = 1'b1;
    #100;
  endtask

  task test_write;
    logic a;
    rx_cnt = 0;
    ack_en = 1'b1;
    start_c;
    wr_byte(8'hA0, a);
    n_chk++; if (a !== 1'b0) begin n_fail++; $display("FAIL wr_addr_ack: got %b want 0", a); end
    n_chk++; if (addressed !== 1'b1 || rw !== 1'b0) begin n_fail++; $display("FAIL wr_addressed_rw: got %b%b want 10", addressed, rw); end
    exp_rx.push_back(8'h3C);
    wr_byte(8'h3C, a);
    n_chk++; if (a !== 1'b0) begin n_fail++; $display("FAIL wr_byte1_ack: got %b want 0", a); end
    exp_rx.push_back(8'h81);
    wr_byte(8'h81, a);
    n_chk++; if (a !== 1'b0) begin n_fail++; $display("FAIL wr_byte2_ack: got %b want 0", a); end
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL wr_busy: got %b want 1", busy); end
    stop_c;
    n_chk++; if (busy !== 1'b0 || addressed !== 1'b0) begin n_fail++; $display("FAIL wr_after_stop: busy/addressed got %b%b want 00", busy, addressed); end
    n_chk++; if (rx_cnt != 2 || exp_rx.size() != 0) begin n_fail++; $display("FAIL wr_rx_count: got %0d pulses, %0d pending want 2, 0", rx_cnt, exp_rx.size()); end
  endtask

  task test_nomatch;
    logic a;
    rx_cnt = 0;
    dut_low = 1'b0;
    start_c;
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL nm_busy_start: got %b want 1", busy); end
    wr_byte(8'hA2, a);
    n_chk++; if (a !== 1'b1) begin n_fail++; $display("FAIL nm_addr_nack: got %b want 1", a); end
    wr_byte(8'h55, a);
    n_chk++; if (a !== 1'b1) begin n_fail++; $display("FAIL nm_data_nack: got %b want 1", a); end
    n_chk++; if (addressed !== 1'b0 || rx_cnt != 0 || dut_low !== 1'b0) begin n_fail++; $display("FAIL nm_quiet: addressed=%b rx=%0d sda_low=%b want 0 0 0", addressed, rx_cnt, dut_low); end
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL nm_busy_held: got %b want 1", busy); end
    stop_c;
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL nm_busy_stop: got %b want 0", busy); end
  endtask

  task test_read;
    logic a;
    logic [7:0] d, e;
    sd_cnt = 0;
    datasend = 8'h5A;
    ds_q.push_back(8'hC3);
    exp_tx.push_back(8'h5A);
    exp_tx.push_back(8'hC3);
    start_c;
    wr_byte(8'hA1, a);
    n_chk++; if (a !== 1'b0 || rw !== 1'b1) begin n_fail++; $display("FAIL rd_addr: ack=%b rw=%b want 0 1", a, rw); end
    rd_byte(d, 1'b0);
    e = exp_tx.pop_front();
    n_chk++; if (d !== e) begin n_fail++; $display("FAIL rd_byte1: got %h want %h", d, e); end
    rd_byte(d, 1'b1);
    e = exp_tx.pop_front();
    n_chk++; if (d !== e) begin n_fail++; $display("FAIL rd_byte2: got %h want %h", d, e); end
    n_chk++; if (addressed !== 1'b0) begin n_fail++; $display("FAIL rd_nack_addressed: got %b want 0", addressed); end
    n_chk++; if (sd_cnt != 2) begin n_fail++; $display("FAIL rd_sended_count: got %0d want 2", sd_cnt); end
    stop_c;
  endtask

  task test_rstart;
    logic a;
    logic [7:0] d, e;
    ack_en = 1'b1;
    start_c;
    wr_byte(8'hA0, a);
    exp_rx.push_back(8'h10);
    wr_byte(8'h10, a);
    n_chk++; if (a !== 1'b0) begin n_fail++; $display("FAIL rs_write_ack: got %b want 0", a); end
    datasend = 8'hE7;
    exp_tx.push_back(8'hE7);
    start_c;
    n_chk++; if (busy !== 1'b1 || addressed !== 1'b0) begin n_fail++; $display("FAIL rs_restart: busy/addressed got %b%b want 10", busy, addressed); end
    wr_byte(8'hA1, a);
    n_chk++; if (a !== 1'b0 || rw !== 1'b1 || datareceive !== 8'h10) begin n_fail++; $display("FAIL rs_addr: ack=%b rw=%b data=%h want 0 1 10", a, rw, datareceive); end
    rd_byte(d, 1'b1);
    e = exp_tx.pop_front();
    n_chk++; if (d !== e) begin n_fail++; $display("FAIL rs_read: got %h want %h", d, e); end
    stop_c;
  endtask

  task test_nack;
    logic a;
    int rx0;
    ack_en = 1'b1;
    start_c;
    wr_byte(8'hA0, a);
    exp_rx.push_back(8'h11);
    wr_byte(8'h11, a);
    n_chk++; if (a !== 1'b0) begin n_fail++; $display("FAIL nk_byte1_ack: got %b want 0", a); end
    ack_en = 1'b0;
    exp_rx.push_back(8'h22);
    wr_byte(8'h22, a);
    n_chk++; if (a !== 1'b1 || addressed !== 1'b0) begin n_fail++; $display("FAIL nk_byte2: ack=%b addressed=%b want 1 0", a, addressed); end
    rx0 = rx_cnt;
    wr_byte(8'h33, a);
    n_chk++; if (rx_cnt != rx0 || a !== 1'b1) begin n_fail++; $display("FAIL nk_byte3: pulses=%0d ack=%b want %0d 1", rx_cnt - rx0, a, 0); end
    stop_c;
    ack_en = 1'b1;
  endtask

  task test_reset_mid;
    logic a, r;
    logic [7:0] b;
    b = 8'hA0;
    start_c;
    for (int i = 7; i >= 0; i--) sbit(b[i], r);
    m_low = 1'b0;
    #60 scl = 1'b1;
    #40;
    n_chk++; if (sda !== 1'b0) begin n_fail++; $display("FAIL rm_ack_driven: got %b want 0", sda); end
    reset = 1'b0;
    #1;
    n_chk++; if (sda === 1'b0) begin n_fail++; $display("FAIL rm_sda_release: got %b want Z/1", sda); end
    n_chk++; if (busy !== 1'b0 || addressed !== 1'b0 || rw !== 1'b0 || datareceive !== 8'h00 || received !== 1'b0 || sended !== 1'b0) begin
      n_fail++; $display("FAIL rm_outputs: busy=%b addr=%b rw=%b data=%h rx=%b tx=%b want 0 0 0 00 0 0", busy, addressed, rw, datareceive, received, sended);
    end
    #39 scl = 1'b0;
    #40 reset = 1'b1;
    #100;
    start_c;
    wr_byte(8'hA0, a);
    n_chk++; if (a !== 1'b0 || addressed !== 1'b1) begin n_fail++; $display("FAIL rm_after_reset: ack=%b addressed=%b want 0 1", a, addressed); end
    stop_c;
  endtask

  initial begin
    #3;
    test_reset;
    test_write;
    test_nomatch;
    test_read;
    test_rstart;
    test_nack;
    test_reset_mid;
    n_chk++; if (exp_rx.size() != 0) begin n_fail++; $display("FAIL rx_queue_empty: %0d bytes never received", exp_rx.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
